// File: rtl/pattern_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pattern_gen_if
//  Purpose  : Bundles the timing-generator strobes, mode request and the
//             re-aligned pixel output of pattern_gen.
//             master : the side feeding timing/mode and receiving pixels
//             slave  : pattern_gen itself
//  Ports    : mode_in/mode_valid, vs_in/hs_in/de_in, x_in/y_in (to slave)
//             vs_out/hs_out/de_out, r_out/g_out/b_out, frame_cnt, mode_cur
//             (from slave)
//  Revision : 1.0 - initial release
// ============================================================================
interface pattern_gen_if #(
    parameter int X_BITS     = 12,
    parameter int Y_BITS     = 12,
    parameter int COLOR_BITS = 8
);
    logic [2:0]            mode_in;
    logic                  mode_valid;
    logic                  vs_in;
    logic                  hs_in;
    logic                  de_in;
    logic [X_BITS-1:0]     x_in;
    logic [Y_BITS-1:0]     y_in;
    logic                  vs_out;
    logic                  hs_out;
    logic                  de_out;
    logic [COLOR_BITS-1:0] r_out;
    logic [COLOR_BITS-1:0] g_out;
    logic [COLOR_BITS-1:0] b_out;
    logic [15:0]           frame_cnt;
    logic [2:0]            mode_cur;

    modport master (
        output mode_in, mode_valid, vs_in, hs_in, de_in, x_in, y_in,
        input  vs_out, hs_out, de_out, r_out, g_out, b_out, frame_cnt, mode_cur
    );

    modport slave (
        input  mode_in, mode_valid, vs_in, hs_in, de_in, x_in, y_in,
        output vs_out, hs_out, de_out, r_out, g_out, b_out, frame_cnt, mode_cur
    );
endinterface
`default_nettype wire

// File: rtl/pattern_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pattern_gen
//  Purpose  : Video test-pattern generator placed after the timing generator.
//             Turns vs/hs/de + active coordinates into RGB pixels with a
//             fixed 2-cycle latency on every output. Modes:
//             0 white, 1 colour bars, 2 checkerboard, 3 gray ramp,
//             4 bouncing box, 5 grid, 6/7 black.
//             Mode changes land only on a vs_in rising edge.
//  Ports    : clk, rst (sync, active-high), bus (pattern_gen_if.slave)
//  Options  : define PG_BORDER_EN to force a 1-pixel white frame border.
//  Revision : 1.0 - initial release
// ============================================================================
module pattern_gen #(
    parameter int X_BITS     = 12,
    parameter int Y_BITS     = 12,
    parameter int H_ACT      = 640,
    parameter int V_ACT      = 480,
    parameter int COLOR_BITS = 8,
    parameter int BOX_SIZE   = 64
) (
    input  wire logic       clk,
    input  wire logic       rst,
    pattern_gen_if.slave    bus
);
    localparam logic [X_BITS-1:0]     c_bx_max   = X_BITS'(H_ACT - BOX_SIZE);
    localparam logic [Y_BITS-1:0]     c_by_max   = Y_BITS'(V_ACT - BOX_SIZE);
    localparam logic [X_BITS-1:0]     c_bar_last = X_BITS'((H_ACT >> 3) - 1);
    localparam logic [X_BITS-1:0]     c_x_one    = X_BITS'(1);
    localparam logic [Y_BITS-1:0]     c_y_one    = Y_BITS'(1);
    localparam logic [COLOR_BITS-1:0] c_col_ones = '1;
    localparam logic [COLOR_BITS-1:0] c_col_msb  = COLOR_BITS'(1) << (COLOR_BITS - 1);

    // ---------------- frame control ----------------
    logic              r_vs_prev;
    logic [2:0]        r_mode_pend;
    logic [2:0]        r_mode_cur;
    logic [15:0]       r_frame_cnt;
    logic [X_BITS-1:0] r_bx;
    logic [Y_BITS-1:0] r_by;
    logic              r_dir_x;
    logic              r_dir_y;
    logic              w_frame_start;

    assign w_frame_start = bus.vs_in & ~r_vs_prev;

    // mode_cur picks up the pending value as it was before this edge, so a
    // strobe coinciding with frame start only takes effect one frame later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_prev   <= 1'b0;
            r_mode_pend <= 3'd0;
            r_mode_cur  <= 3'd0;
            r_frame_cnt <= 16'd0;
            r_bx        <= '0;
            r_by        <= '0;
            r_dir_x     <= 1'b0;
            r_dir_y     <= 1'b0;
        end else begin
            r_vs_prev <= bus.vs_in;
            if (bus.mode_valid) begin
                r_mode_pend <= bus.mode_in;
            end
            if (w_frame_start) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
                r_mode_cur  <= r_mode_pend;
                // Box bounces between 0 and ACT-BOX_SIZE on each axis.
                if (!r_dir_x) begin
                    if (r_bx == c_bx_max) begin
                        r_dir_x <= 1'b1;
                        r_bx    <= r_bx - c_x_one;
                    end else begin
                        r_bx    <= r_bx + c_x_one;
                    end
                end else begin
                    if (r_bx == '0) begin
                        r_dir_x <= 1'b0;
                        r_bx    <= r_bx + c_x_one;
                    end else begin
                        r_bx    <= r_bx - c_x_one;
                    end
                end
                if (!r_dir_y) begin
                    if (r_by == c_by_max) begin
                        r_dir_y <= 1'b1;
                        r_by    <= r_by - c_y_one;
                    end else begin
                        r_by    <= r_by + c_y_one;
                    end
                end else begin
                    if (r_by == '0) begin
                        r_dir_y <= 1'b0;
                        r_by    <= r_by + c_y_one;
                    end else begin
                        r_by    <= r_by - c_y_one;
                    end
                end
            end
        end
    end

    // ---------------- colour-bar tracker ----------------
    // Registers hold the bar of the pixel currently on x_in; they rewind
    // during blanking so the first active pixel of each line is bar 0.
    logic [X_BITS-1:0] r_bar_cnt;
    logic [2:0]        r_bar_idx;

    always_ff @(posedge clk) begin
        if (rst || !bus.de_in) begin
            r_bar_cnt <= c_bar_last;
            r_bar_idx <= 3'd0;
        end else if (r_bar_cnt == '0) begin
            r_bar_cnt <= c_bar_last;
            if (r_bar_idx != 3'd7) begin
                r_bar_idx <= r_bar_idx + 3'd1;
            end
        end else begin
            r_bar_cnt <= r_bar_cnt - c_x_one;
        end
    end

    // ---------------- stage 1: pattern decision ----------------
    // The decision is kept compact: three on/off channel flags, a gray
    // flag with its ramp value, and a dark-blue flag for the box background.
    logic [X_BITS:0] w_bx_end;
    logic [Y_BITS:0] w_by_end;
    logic            w_in_box;
    logic [2:0]      w_rgb;
    logic            w_gray_en;
    logic            w_dkblue;

    assign w_bx_end = {1'b0, r_bx} + (X_BITS+1)'(BOX_SIZE);
    assign w_by_end = {1'b0, r_by} + (Y_BITS+1)'(BOX_SIZE);
    assign w_in_box = (bus.x_in >= r_bx) && ({1'b0, bus.x_in} < w_bx_end) &&
                      (bus.y_in >= r_by) && ({1'b0, bus.y_in} < w_by_end);

    always_comb begin
        w_rgb     = 3'b000;
        w_gray_en = 1'b0;
        w_dkblue  = 1'b0;
        case (r_mode_cur)
            3'd0: w_rgb = 3'b111;
            3'd1: begin
                case (r_bar_idx)
                    3'd0:    w_rgb = 3'b111;
                    3'd1:    w_rgb = 3'b110;
                    3'd2:    w_rgb = 3'b011;
                    3'd3:    w_rgb = 3'b010;
                    3'd4:    w_rgb = 3'b101;
                    3'd5:    w_rgb = 3'b100;
                    3'd6:    w_rgb = 3'b001;
                    default: w_rgb = 3'b000;
                endcase
            end
            3'd2: w_rgb = {3{bus.x_in[5] ^ bus.y_in[5]}};
            3'd3: w_gray_en = 1'b1;
            3'd4: begin
                if (w_in_box) begin
                    w_rgb = 3'b100;
                end else begin
                    w_dkblue = 1'b1;
                end
            end
            3'd5: w_rgb = {3{(bus.x_in[5:0] == 6'd0) || (bus.y_in[5:0] == 6'd0)}};
            default: w_rgb = 3'b000;
        endcase
`ifdef PG_BORDER_EN
        if ((bus.x_in == '0) || (bus.x_in == X_BITS'(H_ACT - 1)) ||
            (bus.y_in == '0) || (bus.y_in == Y_BITS'(V_ACT - 1))) begin
            w_rgb     = 3'b111;
            w_gray_en = 1'b0;
            w_dkblue  = 1'b0;
        end
`endif
    end

    logic [2:0] r_s1_rgb;
    logic       r_s1_gray_en;
    logic [7:0] r_s1_gray;
    logic       r_s1_dkblue;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_rgb     <= 3'b000;
            r_s1_gray_en <= 1'b0;
            r_s1_gray    <= 8'd0;
            r_s1_dkblue  <= 1'b0;
        end else begin
            r_s1_rgb     <= w_rgb;
            r_s1_gray_en <= w_gray_en;
            r_s1_gray    <= bus.x_in[7:0];
            r_s1_dkblue  <= w_dkblue;
        end
    end

    // Gray ramp left-aligned into the channel width.
    logic [COLOR_BITS-1:0] w_gray_c;
    generate
        if (COLOR_BITS > 8) begin : g_gray_wide
            assign w_gray_c = {r_s1_gray, {(COLOR_BITS-8){1'b0}}};
        end else if (COLOR_BITS == 8) begin : g_gray_eq
            assign w_gray_c = r_s1_gray;
        end else begin : g_gray_narrow
            assign w_gray_c = r_s1_gray[7 -: COLOR_BITS];
        end
    endgenerate

    // ---------------- stage 2: colour + sync alignment ----------------
    logic [1:0]            r_vs_d;
    logic [1:0]            r_hs_d;
    logic [1:0]            r_de_d;
    logic [COLOR_BITS-1:0] r_r;
    logic [COLOR_BITS-1:0] r_g;
    logic [COLOR_BITS-1:0] r_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_d <= 2'b00;
            r_hs_d <= 2'b00;
            r_de_d <= 2'b00;
        end else begin
            r_vs_d <= {r_vs_d[0], bus.vs_in};
            r_hs_d <= {r_hs_d[0], bus.hs_in};
            r_de_d <= {r_de_d[0], bus.de_in};
        end
    end

    // r_de_d[0] becomes de_out on the same edge the colour is registered,
    // so gating on it blanks exactly the pixels where de_out is low.
    always_ff @(posedge clk) begin
        if (rst || !r_de_d[0]) begin
            r_r <= '0;
            r_g <= '0;
            r_b <= '0;
        end else if (r_s1_gray_en) begin
            r_r <= w_gray_c;
            r_g <= w_gray_c;
            r_b <= w_gray_c;
        end else begin
            r_r <= r_s1_rgb[2] ? c_col_ones : '0;
            r_g <= r_s1_rgb[1] ? c_col_ones : '0;
            r_b <= r_s1_rgb[0] ? c_col_ones : (r_s1_dkblue ? c_col_msb : '0);
        end
    end

    assign bus.vs_out    = r_vs_d[1];
    assign bus.hs_out    = r_hs_d[1];
    assign bus.de_out    = r_de_d[1];
    assign bus.r_out     = r_r;
    assign bus.g_out     = r_g;
    assign bus.b_out     = r_b;
    assign bus.frame_cnt = r_frame_cnt;
    assign bus.mode_cur  = r_mode_cur;

endmodule
`default_nettype wire
